// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA raster timing generator; optional frame counter under VGA_FRAME_CNT_EN
module vga_sync_gen #(
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33,
   parameter bit          HSYNC_POL = 1'b0,
   parameter bit          VSYNC_POL = 1'b0
) (
   input  logic        clk,
   input  logic        clr,
   output logic        hsync,
   output logic        vsync,
   output logic        video_on,
   output logic [9:0]  pix_x,
   output logic [9:0]  pix_y,
   output logic        line_start,
   output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
   ,
   output logic [15:0] frame_cnt
`endif
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   // Counter wrap points and decode bounds; decode is done in 11 bits so a
   // bound of exactly 1024 still compares correctly against a 10-bit counter.
   localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
   localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
   localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] HS_STOP  = 11'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] VS_STOP  = 11'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [9:0] hc_q, hc_d;
   logic [9:0] vc_q, vc_d;
   logic       run_q, run_d;

   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic       video_on_q, video_on_d;
   logic       line_start_q, line_start_d;
   logic       frame_start_q, frame_start_d;

   logic [10:0] hx, vy;

   // Next counter state: the first edge after reset only arms the run flag so
   // that (0,0) is presented for a full cycle; afterwards the raster advances.
   always_comb begin
      hc_d  = hc_q;
      vc_d  = vc_q;
      run_d = 1'b1;
      if (run_q) begin
         if (hc_q == H_LAST) begin
            hc_d = '0;
            vc_d = (vc_q == V_LAST) ? '0 : vc_q + 10'd1;
         end else begin
            hc_d = hc_q + 10'd1;
         end
      end
   end

   // Decode the next-state position so registered outputs line up with pix_x/pix_y.
   always_comb begin
      hx            = {1'b0, hc_d};
      vy            = {1'b0, vc_d};
      video_on_d    = (hx < H_VIS) && (vy < V_VIS);
      hsync_d       = ((hx >= HS_START) && (hx < HS_STOP)) ? HSYNC_POL : ~HSYNC_POL;
      vsync_d       = ((vy >= VS_START) && (vy < VS_STOP)) ? VSYNC_POL : ~VSYNC_POL;
      line_start_d  = (hc_d == 10'd0);
      frame_start_d = (hc_d == 10'd0) && (vc_d == 10'd0);
   end

   // Counter, run flag and output registers with asynchronous clear.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         hc_q          <= '0;
         vc_q          <= '0;
         run_q         <= 1'b0;
         hsync_q       <= ~HSYNC_POL;
         vsync_q       <= ~VSYNC_POL;
         video_on_q    <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hc_q          <= hc_d;
         vc_q          <= vc_d;
         run_q         <= run_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         video_on_q    <= video_on_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign video_on    = video_on_q;
   assign pix_x       = hc_q;
   assign pix_y       = vc_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

`ifdef VGA_FRAME_CNT_EN
   logic [15:0] frame_cnt_q;

   // Count frames on the same edge that raises frame_start; wraps naturally.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         frame_cnt_q <= '0;
      end else if (frame_start_d) begin
         frame_cnt_q <= frame_cnt_q + 16'd1;
      end
   end

   assign frame_cnt = frame_cnt_q;
`endif

endmodule
